// File: rtl/program_loader_if.sv
// Word-stream, CU request and RAM port signals of the program loader.
// The slave modport is the loader's view; the master modport is its surroundings.
interface program_loader_if #(
  parameter int unsigned adlines   = 8,
  parameter int unsigned datalines = 16
);
  logic [datalines-1:0] indata;
  logic                 invalid;
  logic                 inlast;
  logic                 inready;
  logic [adlines-1:0]   cuaddress;
  logic [datalines-1:0] cutoram;
  logic                 curead;
  logic                 cuwrite;
  logic [adlines-1:0]   addressbus;
  logic [datalines-1:0] toram;
  logic                 read;
  logic                 write;

  modport slave (
    input  indata, invalid, inlast, cuaddress, cutoram, curead, cuwrite,
    output inready, addressbus, toram, read, write
  );

  modport master (
    output indata, invalid, inlast, cuaddress, cutoram, curead, cuwrite,
    input  inready, addressbus, toram, read, write
  );
endinterface

// File: rtl/program_loader.sv
// Streams a program image into RAM with a 4-cycle setup/strobe/hold write per word,
// then enables the CU and hands it the RAM port.
module program_loader #(
  parameter int unsigned adlines   = 8,
  parameter int unsigned datalines = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [adlines-1:0] baseaddr,
  output logic               cuenable,
  output logic [adlines:0]   wordcount,
  output logic               error,
  program_loader_if.slave    bus
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSetup,
    StStrobe,
    StHold,
    StRun,
    StErr
  } state_e;

  state_e               state_q, state_d;
  logic [adlines-1:0]   ptr_q, ptr_d;
  logic [adlines-1:0]   addr_q, addr_d;
  logic [datalines-1:0] data_q, data_d;
  logic                 last_q, last_d;
  logic [adlines:0]     wordcount_q, wordcount_d;
  logic                 write_q, inready_q, cuenable_q, error_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    last_d      = last_q;
    wordcount_d = wordcount_q;

    unique case (state_q)
      StIdle, StErr: begin
        if (start) begin
          state_d     = StLoad;
          ptr_d       = baseaddr;
          wordcount_d = '0;
        end
      end
      StLoad: begin
        if (bus.invalid && inready_q) begin
          state_d = StSetup;
          addr_d  = ptr_q;
          data_d  = bus.indata;
          last_d  = bus.inlast;
        end
      end
      StSetup:  state_d = StStrobe;
      StStrobe: state_d = StHold;
      StHold: begin
        wordcount_d = wordcount_q + (adlines + 1)'(1);
        if (last_q) begin
          state_d = StRun;
        end else if (ptr_q == '1) begin
          // Pointer never wraps: running off the top is an error, not a rollover.
          state_d = StErr;
        end else begin
          ptr_d   = ptr_q + adlines'(1);
          state_d = StLoad;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StIdle;
    endcase

    // Bus registers only carry a word through its setup/strobe/hold window.
    if (!(state_d inside {StSetup, StStrobe, StHold})) begin
      addr_d = '0;
      data_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      wordcount_q <= '0;
      write_q     <= 1'b0;
      inready_q   <= 1'b0;
      cuenable_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      last_q      <= last_d;
      wordcount_q <= wordcount_d;
      write_q     <= (state_d == StStrobe);
      inready_q   <= (state_d == StLoad);
      cuenable_q  <= (state_d == StRun);
      error_q     <= (state_d == StErr);
    end
  end

  // In RUN the CU owns the RAM port directly, with no register stage.
  assign bus.addressbus = (state_q == StRun) ? bus.cuaddress : addr_q;
  assign bus.toram      = (state_q == StRun) ? bus.cutoram   : data_q;
  assign bus.read       = (state_q == StRun) ? bus.curead    : 1'b0;
  assign bus.write      = (state_q == StRun) ? bus.cuwrite   : write_q;
  assign bus.inready    = inready_q;
  assign cuenable       = cuenable_q;
  assign wordcount      = wordcount_q;
  assign error          = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: an 8-bit-address instance for loading and
// pass-through, and a 4-bit-address instance for the top-of-memory cases.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] baseaddr = '0;
  logic       cuenable;
  logic [8:0] wordcount;
  logic       error;

  logic       resetn4 = 1'b0;
  logic       start4 = 1'b0;
  logic [3:0] baseaddr4 = '0;
  logic       cuenable4;
  logic [4:0] wordcount4;
  logic       error4;

  int checks = 0;
  int failures = 0;

  typedef struct packed {logic [7:0] addr; logic [15:0] data;} wr_t;
  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
    logic        width_ok;
    logic        stable_ok;
  } obs_t;

  wr_t        exp_q[$];
  obs_t       obs_q[$];
  logic [3:0] obs4_q[$];
  logic [15:0] mem [256];

  program_loader_if #(.adlines(8), .datalines(16)) bus ();
  program_loader_if #(.adlines(4), .datalines(16)) bus4 ();

  program_loader #(.adlines(8), .datalines(16)) u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .baseaddr  (baseaddr),
    .cuenable  (cuenable),
    .wordcount (wordcount),
    .error     (error),
    .bus       (bus.slave)
  );

  program_loader #(.adlines(4), .datalines(16)) u_dut4 (
    .clk       (clk),
    .resetn    (resetn4),
    .start     (start4),
    .baseaddr  (baseaddr4),
    .cuenable  (cuenable4),
    .wordcount (wordcount4),
    .error     (error4),
    .bus       (bus4.slave)
  );

  always #5 clk = ~clk;

  // RAM model behind the 8-bit instance.
  always @(posedge clk) begin
    if (bus.write) mem[bus.addressbus] <= bus.toram;
  end

  // Loader write monitor: records each pulse with its width and address/data stability.
  logic        prev_write = 1'b0;
  logic        in_pulse = 1'b0;
  logic [7:0]  prev_addr = '0;
  logic [15:0] prev_data = '0;
  obs_t        cur;
  always @(negedge clk) begin
    if (in_pulse) begin
      cur.width_ok  = !bus.write;
      cur.stable_ok = cur.stable_ok && (bus.addressbus == cur.addr) && (bus.toram == cur.data);
      obs_q.push_back(cur);
      in_pulse = 1'b0;
    end else if (bus.write && !prev_write && !cuenable) begin
      cur.addr      = bus.addressbus;
      cur.data      = bus.toram;
      cur.width_ok  = 1'b1;
      cur.stable_ok = (prev_addr == bus.addressbus) && (prev_data == bus.toram);
      in_pulse      = 1'b1;
    end
    prev_write = bus.write;
    prev_addr  = bus.addressbus;
    prev_data  = bus.toram;
  end

  logic prev_w4 = 1'b0;
  always @(negedge clk) begin
    if (bus4.write && !prev_w4) obs4_q.push_back(bus4.addressbus);
    prev_w4 = bus4.write;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    resetn = 1'b0;
    start = 1'b0;
    bus.invalid = 1'b0;
    bus.inlast = 1'b0;
    bus.indata = '0;
    bus.cuaddress = '0;
    bus.cutoram = '0;
    bus.curead = 1'b0;
    bus.cuwrite = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [7:0] b);
    @(negedge clk);
    baseaddr = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] d, input logic l, input logic [7:0] a);
    int n;
    n = 0;
    @(negedge clk);
    bus.indata = d;
    bus.inlast = l;
    bus.invalid = 1'b1;
    while (!bus.inready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.inready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready: inready=%b after %0d cycles, expected 1", bus.inready, n);
    end
    exp_q.push_back({a, d});
    @(posedge clk);
    #1;
    bus.invalid = 1'b0;
    bus.inlast = 1'b0;
  endtask

  task automatic test_reset();
    bus.invalid = 1'b0;
    bus.inlast = 1'b0;
    bus.indata = '0;
    bus.cuaddress = 8'h33;
    bus.cutoram = 16'hFFFF;
    bus.curead = 1'b1;
    bus.cuwrite = 1'b1;
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if ({cuenable, wordcount, error, bus.inready, bus.write, bus.read, bus.addressbus,
         bus.toram} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h, expected all zero",
               {cuenable, wordcount, error, bus.inready, bus.write, bus.read,
                bus.addressbus, bus.toram});
    end
    resetn = 1'b1;
    bus.invalid = 1'b1;
    bus.indata = 16'h7777;
    repeat (3) @(negedge clk);
    checks++;
    if ({cuenable, wordcount, error, bus.inready, bus.write, bus.read, bus.addressbus,
         bus.toram} !== '0) begin
      failures++;
      $display("FAIL idle_outputs: got %h, expected all zero",
               {cuenable, wordcount, error, bus.inready, bus.write, bus.read,
                bus.addressbus, bus.toram});
    end
    bus.invalid = 1'b0;
    bus.cuaddress = '0;
    bus.cutoram = '0;
    bus.curead = 1'b0;
    bus.cuwrite = 1'b0;
  endtask

  task automatic test_basic_load();
    pulse_start(8'h01);
    send_word(16'h0086, 1'b0, 8'h01);
    send_word(16'h018E, 1'b0, 8'h02);
    send_word(16'h0000, 1'b1, 8'h03);
    // SETUP, STROBE and HOLD of the last word
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (cuenable !== 1'b0) begin
        failures++;
        $display("FAIL cuenable_early: cycle %0d cuenable=%b, expected 0", i, cuenable);
      end
    end
    @(negedge clk);
    checks++;
    if (cuenable !== 1'b1) begin
      failures++;
      $display("FAIL cuenable_rise: cuenable=%b, expected 1", cuenable);
    end
    checks++;
    if (wordcount !== 9'd3) begin
      failures++;
      $display("FAIL basic_wordcount: got %0d, expected 3", wordcount);
    end
    checks++;
    if ({mem[1], mem[2], mem[3]} !== {16'h0086, 16'h018E, 16'h0000}) begin
      failures++;
      $display("FAIL basic_ram: got %h %h %h, expected 0086 018e 0000", mem[1], mem[2], mem[3]);
    end
  endtask

  task automatic test_write_pulse(input string tag);
    wr_t  e;
    obs_t o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL %s_write_missing: no write observed, expected addr %h data %h",
                 tag, e.addr, e.data);
      end else begin
        o = obs_q.pop_front();
        if ({o.addr, o.data, o.width_ok, o.stable_ok} !== {e.addr, e.data, 2'b11}) begin
          failures++;
          $display("FAIL %s_write: got addr %h data %h width_ok %b stable_ok %b, expected %h %h 1 1",
                   tag, o.addr, o.data, o.width_ok, o.stable_ok, e.addr, e.data);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL %s_write_extra: %0d extra writes, expected 0", tag, obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_pass_through();
    @(negedge clk);
    bus.cuaddress = 8'h05;
    bus.cutoram = 16'h00AB;
    bus.cuwrite = 1'b1;
    #1;
    checks++;
    if ({bus.addressbus, bus.toram, bus.write, bus.read} !== {8'h05, 16'h00AB, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL pass_write: got %h %h w%b r%b, expected 05 00ab w1 r0",
               bus.addressbus, bus.toram, bus.write, bus.read);
    end
    @(negedge clk);
    bus.cuwrite = 1'b0;
    bus.curead = 1'b1;
    #1;
    checks++;
    if ({bus.read, bus.write, mem[bus.addressbus]} !== {1'b1, 1'b0, 16'h00AB}) begin
      failures++;
      $display("FAIL pass_read: got r%b w%b ram %h, expected r1 w0 00ab",
               bus.read, bus.write, mem[bus.addressbus]);
    end
    pulse_start(8'h80);
    repeat (2) @(negedge clk);
    checks++;
    if ({cuenable, bus.inready, bus.addressbus} !== {1'b1, 1'b0, 8'h05}) begin
      failures++;
      $display("FAIL run_ignores_start: got cuenable %b inready %b addr %h, expected 1 0 05",
               cuenable, bus.inready, bus.addressbus);
    end
    bus.curead = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    pulse_start(8'h20);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.inready !== (i % 4 == 0)) begin
        failures++;
        $display("FAIL bp_inready: cycle %0d inready=%b, expected %b", i, bus.inready, (i % 4 == 0));
      end
      bus.invalid = 1'b1;
      bus.indata = 16'h1234;
      bus.inlast = 1'b0;
      @(negedge clk);
    end
    bus.invalid = 1'b0;
    exp_q.push_back({8'h20, 16'h1234});
    exp_q.push_back({8'h21, 16'h1234});
    exp_q.push_back({8'h22, 16'h1234});
    repeat (6) @(negedge clk);
    checks++;
    if ({wordcount, bus.inready} !== {9'd3, 1'b1}) begin
      failures++;
      $display("FAIL bp_state: wordcount %0d inready %b, expected 3 1", wordcount, bus.inready);
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    pulse_start(8'h40);
    send_word(16'h5555, 1'b0, 8'h40);
    send_word(16'h6666, 1'b0, 8'h41);
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    checks++;
    if ({bus.write, wordcount} !== {1'b1, 9'd1}) begin
      failures++;
      $display("FAIL mid_strobe: write %b wordcount %0d, expected 1 1", bus.write, wordcount);
    end
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if ({bus.write, cuenable, wordcount} !== '0) begin
      failures++;
      $display("FAIL mid_reset: write %b cuenable %b wordcount %0d, expected 0 0 0",
               bus.write, cuenable, wordcount);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.inready, bus.write, bus.addressbus, bus.toram} !== '0) begin
      failures++;
      $display("FAIL mid_idle: inready %b write %b addr %h data %h, expected all zero",
               bus.inready, bus.write, bus.addressbus, bus.toram);
    end
    pulse_start(8'h50);
    checks++;
    if (bus.inready !== 1'b1) begin
      failures++;
      $display("FAIL mid_restart: inready %b, expected 1", bus.inready);
    end
  endtask

  task automatic test_overflow();
    logic [3:0] a0;
    logic [3:0] a1;
    bus4.invalid = 1'b0;
    bus4.inlast = 1'b0;
    bus4.indata = '0;
    bus4.cuaddress = '0;
    bus4.cutoram = '0;
    bus4.curead = 1'b0;
    bus4.cuwrite = 1'b0;
    resetn4 = 1'b0;
    repeat (2) @(negedge clk);
    resetn4 = 1'b1;
    obs4_q.delete();
    @(negedge clk);
    baseaddr4 = 4'd14;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    bus4.invalid = 1'b1;
    bus4.indata = 16'hBEEF;
    repeat (24) @(negedge clk);
    bus4.invalid = 1'b0;
    checks++;
    if (obs4_q.size() != 2) begin
      failures++;
      $display("FAIL ovf_write_count: %0d writes, expected 2", obs4_q.size());
    end else begin
      a0 = obs4_q[0];
      a1 = obs4_q[1];
      checks++;
      if ({a0, a1} !== {4'd14, 4'd15}) begin
        failures++;
        $display("FAIL ovf_write_addr: got %0d %0d, expected 14 15", a0, a1);
      end
    end
    checks++;
    if ({error4, wordcount4, cuenable4, bus4.inready} !== {1'b1, 5'd2, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL ovf_state: error %b wordcount %0d cuenable %b inready %b, expected 1 2 0 0",
               error4, wordcount4, cuenable4, bus4.inready);
    end
    checks++;
    if ({bus4.addressbus, bus4.toram, bus4.write, bus4.read} !== '0) begin
      failures++;
      $display("FAIL ovf_bus: addr %h data %h w %b r %b, expected all zero",
               bus4.addressbus, bus4.toram, bus4.write, bus4.read);
    end
    baseaddr4 = 4'd0;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    checks++;
    if ({error4, wordcount4, bus4.inready} !== {1'b0, 5'd0, 1'b1}) begin
      failures++;
      $display("FAIL ovf_restart: error %b wordcount %0d inready %b, expected 0 0 1",
               error4, wordcount4, bus4.inready);
    end
    // A last word at the top address completes normally.
    resetn4 = 1'b0;
    @(negedge clk);
    resetn4 = 1'b1;
    @(negedge clk);
    baseaddr4 = 4'd15;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    bus4.invalid = 1'b1;
    bus4.inlast = 1'b1;
    bus4.indata = 16'hCAFE;
    repeat (8) @(negedge clk);
    bus4.invalid = 1'b0;
    bus4.inlast = 1'b0;
    checks++;
    if ({cuenable4, error4, wordcount4} !== {1'b1, 1'b0, 5'd1}) begin
      failures++;
      $display("FAIL top_last: cuenable %b error %b wordcount %0d, expected 1 0 1",
               cuenable4, error4, wordcount4);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_write_pulse("basic");
    test_pass_through();
    test_backpressure();
    test_write_pulse("bp");
    test_reset_mid_load();
    test_write_pulse("mid");
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
